// File: rtl/mccoy_pkg.sv
// McCoy core shared definitions: widths, opcode map,
// instruction field positions, fetch FSM states.
package mccoy_pkg;

  localparam int PC_W    = 6;
  localparam int INSTR_W = 8;
  localparam int QDEPTH  = 2;

  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 5;
  localparam int OPD_MSB = 4;
  localparam int OPD_LSB = 0;

  localparam logic [2:0] OP_LI   = 3'd0;
  localparam logic [2:0] OP_JA   = 3'd1;
  localparam logic [2:0] OP_BEZ  = 3'd2;
  localparam logic [2:0] OP_ADD  = 3'd3;
  localparam logic [2:0] OP_LR   = 3'd4;
  localparam logic [2:0] OP_NOT  = 3'd5;
  localparam logic [2:0] OP_SR   = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_REQ  = 2'd1,
    F_GAP  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry prefetch FIFO of {instr, pc}; flush beats push/pop.
// Ports: push/push_data in, pop in, flush in, count/head out.
module fetch_queue
  import mccoy_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  fq_entry_t  push_data,
  input  logic       pop,
  input  logic       flush,
  output logic [1:0] count,
  output fq_entry_t  head
);

  fq_entry_t  e0;
  fq_entry_t  e1;
  logic [1:0] cnt;
  logic       do_pop;

  assign do_pop = pop && (cnt != 2'd0);
  assign count  = cnt;
  assign head   = e0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0  <= '0;
      e1  <= '0;
      cnt <= 2'd0;
    end else if (flush) begin
      cnt <= 2'd0;
    end else begin
      unique case ({push, do_pop})
        2'b10: begin
          if (cnt == 2'd0) e0 <= push_data;
          else             e1 <= push_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            e0 <= push_data;
          end else begin
            e0 <= e1;
            e1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// McCoy fetch stage: req/ack program memory fetch into a 2-entry
// prefetch queue; head presented as opcode/operand/pc with valid/ready;
// redirect flushes and restarts; HALT stops prefetch.
module fetch_unit
  import mccoy_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  output logic               mem_req,
  output logic [PC_W-1:0]    mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [2:0]         opcode,
  output logic [4:0]         operand,
  output logic [PC_W-1:0]    instr_pc,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_target,
  output logic               halted
);

  fetch_state_e    state;
  fetch_state_e    state_d;
  logic [PC_W-1:0] fetch_pc;
  logic            discard;
  logic [1:0]      count;
  fq_entry_t       head;
  fq_entry_t       push_data;
  logic            acked;
  logic            keep;
  logic            issue;
  logic            start;

  assign mem_req = (state == F_REQ);
  assign acked   = mem_req && mem_ack;
  assign keep    = acked && !discard && !redirect;

  // A redirect cycle never issues: fetch_pc only holds
  // the target from the next cycle on.
  assign issue = !halted && !redirect && (count < 2'd2);
  assign start = (state != F_REQ) && (state_d == F_REQ);

  assign push_data.instr = mem_data;
  assign push_data.pc    = mem_addr;

  always_comb begin
    state_d = state;
    unique case (state)
      F_IDLE:  if (issue) state_d = F_REQ;
      F_REQ:   if (mem_ack) state_d = F_GAP;
      F_GAP:   state_d = issue ? F_REQ : F_IDLE;
      default: state_d = F_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= F_IDLE;
      mem_addr <= '0;
      fetch_pc <= '0;
      halted   <= 1'b0;
      discard  <= 1'b0;
    end else begin
      state <= state_d;
      if (start) mem_addr <= fetch_pc;
      if (redirect)  fetch_pc <= redirect_target;
      else if (keep) fetch_pc <= mem_addr + 6'd1;
      if (redirect) halted <= 1'b0;
      else if (keep && mem_data[OPC_MSB:OPC_LSB] == OP_HALT)
        halted <= 1'b1;
      // Stale in-flight byte must be dropped when it returns.
      if (acked)                    discard <= 1'b0;
      else if (redirect && mem_req) discard <= 1'b1;
    end
  end

  fetch_queue u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (keep),
    .push_data (push_data),
    .pop       (instr_valid && instr_ready),
    .flush     (redirect),
    .count     (count),
    .head      (head)
  );

  assign instr_valid = (count != 2'd0);
  assign opcode      = head.instr[OPC_MSB:OPC_LSB];
  assign operand     = head.instr[OPD_MSB:OPD_LSB];
  assign instr_pc    = head.pc;

endmodule
